// File: rtl/eth_speed_pkg.sv
// eth_speed_pkg
//   Shared types and helpers for the multi-channel RGMII link-speed detector.
//   speed_class_e : per-window classification (low two bits match the speed encoding)
//   det_state_e   : per-port hysteresis state
//   SPEED_RESET   : speed value presented out of reset (1000M encoding)
//   classify()    : maps an edge count onto a speed class using unsigned >= thresholds
package eth_speed_pkg;

   typedef enum logic [2:0] {SPD_10, SPD_100, SPD_1000, SPD_NONE} speed_class_e;
   typedef enum logic {ST_TRACK, ST_CONFIRM} det_state_e;

   localparam logic [1:0] SPEED_RESET = 2'b10;

   function automatic speed_class_e classify(input int unsigned edges,
                                             input int unsigned thr_1000,
                                             input int unsigned thr_100,
                                             input int unsigned thr_10);
      if (edges >= thr_1000)     return SPD_1000;
      else if (edges >= thr_100) return SPD_100;
      else if (edges >= thr_10)  return SPD_10;
      else                       return SPD_NONE;
   endfunction

endpackage

// File: rtl/eth_speed_detect_chan.sv
// eth_speed_detect_chan
//   One port of the speed detector: synchronises the async prescaled RX-clock
//   toggle, counts its edges per window, classifies at window end and filters
//   the result through a TRACK/CONFIRM hysteresis FSM.
//   i_clk / i_rst_n   : gtx_clk domain, async active-low reset
//   i_tog             : async toggle (rx_clk/8)
//   i_restart         : abort window, clear count and hysteresis
//   i_window_end      : last cycle of the shared measurement window
//   o_speed           : 00=10M 01=100M 10=1000M (held while link is down)
//   o_link_valid      : last committed class is not NO_LINK
//   o_speed_change    : 1-cycle pulse when o_speed or o_link_valid changes
module eth_speed_detect_chan
   import eth_speed_pkg::*;
#(
   parameter int WINDOW_CYCLES = 1024,
   parameter int THR_1000      = 160,
   parameter int THR_100       = 25,
   parameter int THR_10        = 2,
   parameter int STABLE_COUNT  = 2,
   parameter int SYNC_STAGES   = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_tog,
   input  logic       i_restart,
   input  logic       i_window_end,
   output logic [1:0] o_speed,
   output logic       o_link_valid,
   output logic       o_speed_change
);

   localparam int            CW      = $clog2(WINDOW_CYCLES + 1);
   localparam int            SW      = $clog2(STABLE_COUNT + 1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [SW-1:0] STAB_N  = SW'(STABLE_COUNT);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic [CW-1:0]          r_cnt;
   det_state_e             r_state, w_state_nx;
   speed_class_e           r_cand, w_cand_nx, r_stable, w_class;
   logic [SW-1:0]          r_stab, w_stab_nx;
   logic [1:0]             r_speed, w_speed_nx;
   logic                   r_link, w_link_nx, r_chg, w_chg_nx;
   logic                   w_edge, w_commit;
   logic [CW-1:0]          w_cnt_tot;

   assign w_edge = r_sync[SYNC_STAGES-1] ^ r_hist;

   // The edge seen on the window_end cycle belongs to the closing window,
   // so classification uses the count including it; the next window starts at 0.
   assign w_cnt_tot = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(w_edge);
   assign w_class   = classify(32'(w_cnt_tot), THR_1000, THR_100, THR_10);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_hist <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_tog};
         r_hist <= r_sync[SYNC_STAGES-1];
         if (i_restart || i_window_end) r_cnt <= '0;
         else                           r_cnt <= w_cnt_tot;
      end
   end

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_TRACK;
         r_cand   <= SPD_NONE;
         r_stable <= SPD_NONE;
         r_stab   <= '0;
         r_speed  <= SPEED_RESET;
         r_link   <= 1'b0;
         r_chg    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cand  <= w_cand_nx;
         r_stab  <= w_stab_nx;
         if (w_commit) r_stable <= w_class;
         r_speed <= w_speed_nx;
         r_link  <= w_link_nx;
         r_chg   <= w_chg_nx;
      end
   end

   // next state; restart has priority over a coincident window end
   always_comb begin
      w_state_nx = r_state;
      w_cand_nx  = r_cand;
      w_stab_nx  = r_stab;
      w_commit   = 1'b0;
      if (i_restart) begin
         w_state_nx = ST_TRACK;
         w_stab_nx  = '0;
      end else if (i_window_end) begin
         case (r_state)
            ST_TRACK: begin
               if (w_class == r_stable) begin
                  w_stab_nx = '0;
               end else begin
                  w_cand_nx = w_class;
                  w_stab_nx = SW'(1);
                  if (STABLE_COUNT == 1) begin
                     w_commit  = 1'b1;
                     w_stab_nx = '0;
                  end else begin
                     w_state_nx = ST_CONFIRM;
                  end
               end
            end
            ST_CONFIRM: begin
               if (w_class == r_cand) begin
                  w_stab_nx = r_stab + SW'(1);
                  if (r_stab + SW'(1) == STAB_N) begin
                     w_commit   = 1'b1;
                     w_state_nx = ST_TRACK;
                     w_stab_nx  = '0;
                  end
               end else if (w_class == r_stable) begin
                  w_state_nx = ST_TRACK;
                  w_stab_nx  = '0;
               end else begin
                  w_cand_nx = w_class;
                  w_stab_nx = SW'(1);
               end
            end
            default: w_state_nx = ST_TRACK;
         endcase
      end
   end

   // outputs: NO_LINK drops link but keeps the last known speed
   always_comb begin
      w_speed_nx = r_speed;
      w_link_nx  = r_link;
      if (w_commit) begin
         if (w_class != SPD_NONE) begin
            w_speed_nx = w_class[1:0];
            w_link_nx  = 1'b1;
         end else begin
            w_link_nx  = 1'b0;
         end
      end
      w_chg_nx = (w_speed_nx != r_speed) || (w_link_nx != r_link);
   end

   assign o_speed        = r_speed;
   assign o_link_valid   = r_link;
   assign o_speed_change = r_chg;

endmodule

// File: rtl/eth_speed_detect_multi.sv
// eth_speed_detect_multi
//   Multi-channel RGMII link-speed detector on gtx_clk. Holds the shared
//   measurement-window counter and packs per-port results.
//   gtx_clk, gtx_rst_n : reference clock, async active-low reset
//   rx_prescale_tog    : per-port async rx_clk/8 toggle
//   meas_restart       : sync pulse, restart window and hysteresis
//   speed              : 2 bits per port (00=10M 01=100M 10=1000M)
//   mii_select         : per port, speed != 1000M
//   link_valid         : per port link up
//   speed_change       : per port 1-cycle update pulse
module eth_speed_detect_multi
   import eth_speed_pkg::*;
#(
   parameter int NUM_CH        = 2,
   parameter int WINDOW_CYCLES = 1024,
   parameter int THR_1000      = 160,
   parameter int THR_100       = 25,
   parameter int THR_10        = 2,
   parameter int STABLE_COUNT  = 2,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                gtx_clk,
   input  logic                gtx_rst_n,
   input  logic [NUM_CH-1:0]   rx_prescale_tog,
   input  logic                meas_restart,
   output logic [2*NUM_CH-1:0] speed,
   output logic [NUM_CH-1:0]   mii_select,
   output logic [NUM_CH-1:0]   link_valid,
   output logic [NUM_CH-1:0]   speed_change
);

   localparam int WW = $clog2(WINDOW_CYCLES);

   logic [WW-1:0]          r_win;
   logic                   w_window_end;
   logic [NUM_CH-1:0][1:0] w_speed;

   assign w_window_end = (r_win == WW'(WINDOW_CYCLES - 1));

   always_ff @(posedge gtx_clk or negedge gtx_rst_n) begin
      if (!gtx_rst_n)                        r_win <= '0;
      else if (meas_restart || w_window_end) r_win <= '0;
      else                                   r_win <= r_win + WW'(1);
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      eth_speed_detect_chan #(
         .WINDOW_CYCLES (WINDOW_CYCLES),
         .THR_1000      (THR_1000),
         .THR_100       (THR_100),
         .THR_10        (THR_10),
         .STABLE_COUNT  (STABLE_COUNT),
         .SYNC_STAGES   (SYNC_STAGES)
      ) u_chan (
         .i_clk          (gtx_clk),
         .i_rst_n        (gtx_rst_n),
         .i_tog          (rx_prescale_tog[g]),
         .i_restart      (meas_restart),
         .i_window_end   (w_window_end),
         .o_speed        (w_speed[g]),
         .o_link_valid   (link_valid[g]),
         .o_speed_change (speed_change[g])
      );
      assign mii_select[g] = (w_speed[g] != SPEED_RESET);
   end

   assign speed = w_speed;

endmodule

// File: tb/tb_eth_speed_detect_multi.sv
// tb_eth_speed_detect_multi
//   Directed bench: per-port toggle generators at fixed edge rates, a
//   window-level reference model (edge tally per window, class by threshold,
//   commit when the last N classes agree and differ from the committed one),
//   a per-cycle compare, and literal checks at the key window boundaries.
module tb_eth_speed_detect_multi;

   localparam int W = 1024;
   localparam int S = 2;
   localparam int N = 2;

   logic       gtx_clk      = 1'b0;
   logic       gtx_rst_n    = 1'b0;
   logic       meas_restart = 1'b0;
   logic [1:0] tog          = 2'b00;
   logic [3:0] speed;
   logic [1:0] mii_select, link_valid, speed_change;

   int nvec = 0, nerr = 0, t = 0;
   int half[2] = '{0, 0};
   int ph[2]   = '{0, 0};
   int pc[2]   = '{0, 0};

   eth_speed_detect_multi #(
      .NUM_CH(2), .WINDOW_CYCLES(W), .THR_1000(160), .THR_100(25),
      .THR_10(2), .STABLE_COUNT(N), .SYNC_STAGES(S)
   ) dut (
      .gtx_clk         (gtx_clk),
      .gtx_rst_n       (gtx_rst_n),
      .rx_prescale_tog (tog),
      .meas_restart    (meas_restart),
      .speed           (speed),
      .mii_select      (mii_select),
      .link_valid      (link_valid),
      .speed_change    (speed_change)
   );

   initial forever #4 gtx_clk = ~gtx_clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [S+1:0] hv[2];        // input history, bit k = value sampled k edges ago
   int           wc;           // position inside the window
   int           ec[2];        // edges tallied in the open window
   int           run[2];       // length of the current run of identical classes
   int           last[2];      // class of that run
   int           stab[2];      // committed class (3 = no link)
   logic [1:0]   m_speed[2];
   logic         m_link[2], m_chg[2];

   function automatic int m_class(input int e);
      if (e >= 160)     return 2;
      else if (e >= 25) return 1;
      else if (e >= 2)  return 0;
      else              return 3;
   endfunction

   task automatic m_reset();
      wc = 0;
      for (int c = 0; c < 2; c++) begin
         hv[c] = '0; ec[c] = 0; run[c] = 0; last[c] = 3; stab[c] = 3;
         m_speed[c] = 2'b10; m_link[c] = 1'b0; m_chg[c] = 1'b0;
      end
   endtask

   task automatic m_eval(input int c, input int x);
      logic [1:0] nsp;
      logic       nl;
      if (run[c] > 0 && x == last[c]) run[c]++;
      else begin last[c] = x; run[c] = 1; end
      if (x != stab[c] && run[c] >= N) begin
         stab[c] = x;
         nsp = (x != 3) ? 2'(x) : m_speed[c];
         nl  = (x != 3);
         m_chg[c]   = (nsp != m_speed[c]) || (nl != m_link[c]);
         m_speed[c] = nsp;
         m_link[c]  = nl;
      end
   endtask

   task automatic m_step();
      int e;
      for (int c = 0; c < 2; c++) begin
         hv[c]    = {hv[c][S:0], tog[c]};
         m_chg[c] = 1'b0;
      end
      if (meas_restart) begin
         wc = 0;
         for (int c = 0; c < 2; c++) begin ec[c] = 0; run[c] = 0; end
      end else begin
         for (int c = 0; c < 2; c++) begin
            // an input change becomes a counted edge S+1 samples later
            e = int'(hv[c][S] ^ hv[c][S+1]);
            if (wc == W - 1) begin
               m_eval(c, m_class(ec[c] + e));
               ec[c] = 0;
            end else begin
               ec[c] = ec[c] + e;
            end
         end
         wc = (wc == W - 1) ? 0 : wc + 1;
      end
   endtask

   function automatic logic [9:0] m_vec();
      return {m_speed[1], m_speed[0], m_speed[1] != 2'b10, m_speed[0] != 2'b10,
              m_link[1], m_link[0], m_chg[1], m_chg[0]};
   endfunction

   initial begin
      m_reset();
      forever begin
         @(posedge gtx_clk or negedge gtx_rst_n);
         if (!gtx_rst_n) m_reset();
         else            m_step();
      end
   end

   // per-cycle compare
   initial begin
      @(posedge gtx_clk);
      forever begin
         @(negedge gtx_clk);
         chk("cycle", 16'({speed, mii_select, link_valid, speed_change}), 16'(m_vec()));
      end
   end

   // speed_change pulse tally
   initial forever begin
      @(negedge gtx_clk);
      for (int c = 0; c < 2; c++) if (speed_change[c]) pc[c]++;
   end

   // toggle generators: flip every half[c] cycles, half==0 stops
   initial forever begin
      @(posedge gtx_clk); #2;
      for (int c = 0; c < 2; c++) begin
         if (half[c] == 0) ph[c] = 0;
         else begin
            ph[c]++;
            if (ph[c] >= half[c]) begin ph[c] = 0; tog[c] = ~tog[c]; end
         end
      end
   end

   // t counts clock edges since reset release; returns #1 after edge 'target'
   task automatic goto(input int target);
      while (t < target) begin @(posedge gtx_clk); #1; t++; end
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int b;
      repeat (3) @(posedge gtx_clk);
      #1;
      chk("reset_state", 16'({speed, mii_select, link_valid, speed_change}), 16'(10'b1010_00_00_00));
      gtx_rst_n = 1'b1;
      t = 0;

      // 1: ch0 at 256 edges/window -> link up at 1000M after two windows
      half[0] = 4;
      b = pc[0];
      goto(2047);
      chk("t1_link_before", 16'(link_valid[0]), 16'd0);
      goto(2048);
      chk("t1_speed0", 16'(speed[1:0]), 16'b10);
      chk("t1_link0", 16'(link_valid[0]), 16'd1);
      goto(2049);
      chk("t1_pulses0", 16'(pc[0] - b), 16'd1);

      // 2: ch1 at ~51 edges/window -> 100M after two windows
      half[1] = 20;
      goto(4095);
      chk("t2_speed1_before", 16'(speed[3:2]), 16'b10);
      chk("t2_mii1_before", 16'(mii_select[1]), 16'd0);
      goto(4096);
      chk("t2_speed1", 16'(speed[3:2]), 16'b01);
      chk("t2_mii1", 16'(mii_select[1]), 16'd1);
      chk("t2_link1", 16'(link_valid[1]), 16'd1);
      chk("t2_speed0_held", 16'(speed[1:0]), 16'b10);

      // 3: one slow window on ch0 is filtered out
      b = pc[0];
      half[0] = 200;
      goto(5120);
      half[0] = 4;
      goto(6144);
      chk("t3_pulses0", 16'(pc[0] - b), 16'd0);
      chk("t3_speed0", 16'(speed[1:0]), 16'b10);
      chk("t3_link0", 16'(link_valid[0]), 16'd1);

      // 4: ch0 stops -> link down after two windows, speed held
      b = pc[0];
      half[0] = 0;
      goto(8191);
      chk("t4_link_before", 16'(link_valid[0]), 16'd1);
      goto(8192);
      chk("t4_link0", 16'(link_valid[0]), 16'd0);
      chk("t4_speed0", 16'(speed[1:0]), 16'b10);
      chk("t4_mii0", 16'(mii_select[0]), 16'd0);
      goto(8193);
      chk("t4_pulses0", 16'(pc[0] - b), 16'd1);

      // 5: ch1 stops; restart on the committing window_end defers the drop
      b = pc[1];
      half[1] = 0;
      goto(10239);
      meas_restart = 1'b1;
      goto(10240);
      meas_restart = 1'b0;
      chk("t5_link1_restart", 16'(link_valid[1]), 16'd1);
      goto(11264);
      chk("t5_link1_one_window", 16'(link_valid[1]), 16'd1);
      goto(12288);
      chk("t5_link1_down", 16'(link_valid[1]), 16'd0);
      chk("t5_speed1_held", 16'(speed[3:2]), 16'b01);
      goto(12289);
      chk("t5_pulses1", 16'(pc[1] - b), 16'd1);

      // 6: async reset mid-window while ch0 is confirming
      half[0] = 4;
      goto(13800);
      #1 gtx_rst_n = 1'b0;
      #1;
      chk("t6_async_reset", 16'({speed, mii_select, link_valid, speed_change}), 16'(10'b1010_00_00_00));
      repeat (3) @(posedge gtx_clk);
      #1;
      gtx_rst_n = 1'b1;
      t = 0;
      goto(2048);
      chk("t6_relock_link0", 16'(link_valid[0]), 16'd1);
      chk("t6_relock_speed0", 16'(speed[1:0]), 16'b10);
      chk("t6_link1", 16'(link_valid[1]), 16'd0);
      goto(2052);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
